// File: rtl/qam_modulator_gen_pkg.sv
// Shared types and helpers for the generic QAM modulator: constellation modes,
// FSM states, bits-per-axis per mode and the Gray-coded axis level mapping.
package qam_modulator_gen_pkg;

    typedef enum logic [1:0] {
        QAM_BPSK = 2'd0,
        QAM_QPSK = 2'd1,
        QAM_16   = 2'd2,
        QAM_64   = 2'd3
    } qam_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } qam_state_e;

    localparam int unsigned BITS_BPSK = 1;
    localparam int unsigned BITS_QPSK = 1;
    localparam int unsigned BITS_16   = 2;
    localparam int unsigned BITS_64   = 3;

    localparam int AMP_W = 4;

    function automatic int unsigned bits_per_axis(input qam_mode_e mode);
        int unsigned k;
        case (mode)
            QAM_BPSK: k = BITS_BPSK;
            QAM_QPSK: k = BITS_QPSK;
            QAM_16:   k = BITS_16;
            default:  k = BITS_64;
        endcase
        return k;
    endfunction

    // Zero-padded upper Gray bits decode to zero, so one 3-bit decoder serves every k.
    function automatic logic signed [AMP_W-1:0] axis_level(input logic [2:0] bits,
                                                           input int unsigned k);
        logic [2:0] b;
        logic [2:0] g;
        int         lvl;
        b    = bits & 3'((1 << k) - 1);
        g[2] = b[2];
        g[1] = b[2] ^ b[1];
        g[0] = g[1] ^ b[0];
        lvl  = 2 * int'(g) - ((1 << k) - 1);
        return AMP_W'(lvl);
    endfunction

endpackage

// File: rtl/qam_modulator_gen_if.sv
// Symbol handshake between the symbol source (master) and the modulator (slave).
interface qam_modulator_gen_if #(
    parameter int MAX_BITS = 6
);
    logic [MAX_BITS-1:0] ipSymbol;
    logic                ipSymbolValid;
    logic                opSymbolReady;

    modport master (
        output ipSymbol,
        output ipSymbolValid,
        input  opSymbolReady
    );

    modport slave (
        input  ipSymbol,
        input  ipSymbolValid,
        output opSymbolReady
    );
endinterface

// File: rtl/qam_modulator_gen_symbol_fifo.sv
// Small synchronous symbol FIFO with occupancy output; no write-to-read bypass,
// so a pushed word is poppable from the following cycle onwards.
module qam_modulator_gen_symbol_fifo #(
    parameter  int WIDTH = 6,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LVL_W-1:0] level_o,
    output logic             ready_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign ready_o = (count_q != LVL_W'(DEPTH));
    assign level_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Callers only push when ready and pop when non-empty; the guards keep the level sane regardless.
    assign do_push = push_i && ready_o;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/qam_modulator_gen.sv
// Generic BPSK..64-QAM modulator: buffers symbols, holds each for a programmable
// number of ticks, Gray-maps it to I/Q amplitudes and mixes with the NCO carrier.
module qam_modulator_gen
    import qam_modulator_gen_pkg::*;
#(
    parameter  int DATA_W     = 18,
    parameter  int OUT_W      = 20,
    parameter  int MAX_BITS   = 6,
    parameter  int FIFO_DEPTH = 8,
    parameter  int TICK_W     = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     ipClk,
    input  logic                     ipReset,
    input  logic                     ipEnable,
    input  logic [1:0]               ipMode,
    input  logic [TICK_W-1:0]        ipSymbolTicks,
    qam_modulator_gen_if.slave       sym_if,
    input  logic signed [DATA_W-1:0] ipI,
    input  logic signed [DATA_W-1:0] ipQ,
    output logic signed [OUT_W-1:0]  opModulated,
    output logic                     opModulatedValid,
    output logic                     opSymbolStrobe,
    output logic                     opUnderflow,
    output logic [LVL_W-1:0]         opFifoLevel
);

    localparam int PROD_W = DATA_W + AMP_W;
    localparam int SUM_W  = DATA_W + 5;
    localparam int SHIFT  = SUM_W - OUT_W;

    qam_state_e                state_q, state_d;
    qam_mode_e                 mode_q, mode_d;
    logic [MAX_BITS-1:0]       sym_q, sym_d;
    logic [TICK_W-1:0]         cnt_q, cnt_d;
    logic                      strobe_q, strobe_d;
    logic                      underflow_q, underflow_d;
    logic                      load;

    logic                      fifo_ready;
    logic                      fifo_push;
    logic [MAX_BITS-1:0]       fifo_head;
    logic [LVL_W-1:0]          fifo_level;

    logic [5:0]                sym6;
    logic signed [AMP_W-1:0]   amp_i, amp_q;
    logic signed [PROD_W-1:0]  prod_i_q, prod_i_d;
    logic signed [PROD_W-1:0]  prod_q_q, prod_q_d;
    logic signed [SUM_W-1:0]   sum;
    logic signed [OUT_W-1:0]   out_q, out_d;
    logic                      act_d1_q, act_d1_d;
    logic                      valid_q, valid_d;

    assign fifo_push            = sym_if.ipSymbolValid && fifo_ready;
    assign sym_if.opSymbolReady = fifo_ready;

    qam_modulator_gen_symbol_fifo #(
        .WIDTH (MAX_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_symbol_fifo (
        .clk     (ipClk),
        .rst_n   (ipReset),
        .push_i  (fifo_push),
        .wdata_i (sym_if.ipSymbol),
        .pop_i   (load),
        .rdata_o (fifo_head),
        .level_o (fifo_level),
        .ready_o (fifo_ready)
    );

    // Symbol sequencer: a load pops the FIFO and samples mode/ticks; nothing else reads them.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sym_d       = sym_q;
        cnt_d       = cnt_q;
        strobe_d    = 1'b0;
        underflow_d = 1'b0;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ipEnable && fifo_level != '0) begin
                    load = 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - TICK_W'(1);
                end else if (ipEnable && fifo_level != '0) begin
                    load = 1'b1;
                end else begin
                    state_d     = IDLE;
                    underflow_d = ipEnable;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d  = ACTIVE;
            sym_d    = fifo_head;
            mode_d   = qam_mode_e'(ipMode);
            cnt_d    = (ipSymbolTicks == '0) ? '0 : ipSymbolTicks - TICK_W'(1);
            strobe_d = 1'b1;
        end
    end

    // Unused high symbol bits are dropped by the per-mode slices below.
    always_comb begin
        sym6  = 6'(sym_q);
        amp_i = '0;
        amp_q = '0;
        case (mode_q)
            QAM_BPSK: begin
                amp_i = axis_level({2'b00, sym6[0]}, bits_per_axis(QAM_BPSK));
            end
            QAM_QPSK: begin
                amp_i = axis_level({2'b00, sym6[1]}, bits_per_axis(QAM_QPSK));
                amp_q = axis_level({2'b00, sym6[0]}, bits_per_axis(QAM_QPSK));
            end
            QAM_16: begin
                amp_i = axis_level({1'b0, sym6[3:2]}, bits_per_axis(QAM_16));
                amp_q = axis_level({1'b0, sym6[1:0]}, bits_per_axis(QAM_16));
            end
            default: begin
                amp_i = axis_level(sym6[5:3], bits_per_axis(QAM_64));
                amp_q = axis_level(sym6[2:0], bits_per_axis(QAM_64));
            end
        endcase
        if (state_q != ACTIVE) begin
            amp_i = '0;
            amp_q = '0;
        end
    end

    // Two-stage mixer: products first, then the full-precision difference and arithmetic shift.
    always_comb begin
        prod_i_d = PROD_W'(ipI) * PROD_W'(amp_i);
        prod_q_d = PROD_W'(ipQ) * PROD_W'(amp_q);
        sum      = SUM_W'(prod_i_q) - SUM_W'(prod_q_q);
        out_d    = OUT_W'(sum >>> SHIFT);
        act_d1_d = (state_q == ACTIVE);
        valid_d  = act_d1_q;
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q     <= IDLE;
            mode_q      <= QAM_BPSK;
            sym_q       <= '0;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
            prod_i_q    <= '0;
            prod_q_q    <= '0;
            out_q       <= '0;
            act_d1_q    <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sym_q       <= sym_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            underflow_q <= underflow_d;
            prod_i_q    <= prod_i_d;
            prod_q_q    <= prod_q_d;
            out_q       <= out_d;
            act_d1_q    <= act_d1_d;
            valid_q     <= valid_d;
        end
    end

    assign opModulated      = out_q;
    assign opModulatedValid = valid_q;
    assign opSymbolStrobe   = strobe_q;
    assign opUnderflow      = underflow_q;
    assign opFifoLevel      = fifo_level;

endmodule

// File: tb/tb_qam_modulator_gen.sv
// Directed and randomized bench for qam_modulator_gen against a queue-based
// behavioural model of symbol buffering, timing, Gray mapping and mixing.
module tb_qam_modulator_gen;

    localparam int DATA_W     = 18;
    localparam int OUT_W      = 20;
    localparam int MAX_BITS   = 6;
    localparam int FIFO_DEPTH = 8;
    localparam int TICK_W     = 16;
    localparam int SHIFT      = DATA_W + 5 - OUT_W;

    logic                     ipClk = 1'b0;
    logic                     ipReset;
    logic                     ipEnable;
    logic [1:0]               ipMode;
    logic [TICK_W-1:0]        ipSymbolTicks;
    logic signed [DATA_W-1:0] ipI, ipQ;
    logic signed [OUT_W-1:0]  opModulated;
    logic                     opModulatedValid, opSymbolStrobe, opUnderflow;
    logic [3:0]               opFifoLevel;

    int total = 0;
    int bad   = 0;

    qam_modulator_gen_if #(.MAX_BITS(MAX_BITS)) sym_if ();

    qam_modulator_gen #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .MAX_BITS(MAX_BITS),
        .FIFO_DEPTH(FIFO_DEPTH), .TICK_W(TICK_W)
    ) dut (
        .ipClk            (ipClk),
        .ipReset          (ipReset),
        .ipEnable         (ipEnable),
        .ipMode           (ipMode),
        .ipSymbolTicks    (ipSymbolTicks),
        .sym_if           (sym_if.slave),
        .ipI              (ipI),
        .ipQ              (ipQ),
        .opModulated      (opModulated),
        .opModulatedValid (opModulatedValid),
        .opSymbolStrobe   (opSymbolStrobe),
        .opUnderflow      (opUnderflow),
        .opFifoLevel      (opFifoLevel)
    );

    always #5 ipClk = ~ipClk;

    // Reference model state: FIFO as a queue, remaining ticks of the current symbol,
    // and the two-cycle mixer delay as plain integers.
    int     m_q[$];
    bit     m_active;
    int     m_rem, m_sym, m_mode;
    longint m_s1, m_out;
    bit     m_v1, m_valid, m_strobe, m_under;

    function automatic int gray2bin(input int gbits, input int k);
        int b = 0;
        for (int i = k - 1; i >= 0; i--) begin
            b = b | ((((gbits >> i) & 1) ^ ((b >> (i + 1)) & 1)) << i);
        end
        return b;
    endfunction

    function automatic int axisLevel(input int gbits, input int k);
        return 2 * gray2bin(gbits, k) - ((1 << k) - 1);
    endfunction

    function automatic int ampI(input int s, input int mode);
        case (mode)
            0:       return axisLevel(s & 1, 1);
            1:       return axisLevel((s >> 1) & 1, 1);
            2:       return axisLevel((s >> 2) & 3, 2);
            default: return axisLevel((s >> 3) & 7, 3);
        endcase
    endfunction

    function automatic int ampQ(input int s, input int mode);
        case (mode)
            0:       return 0;
            1:       return axisLevel(s & 1, 1);
            2:       return axisLevel(s & 3, 2);
            default: return axisLevel(s & 7, 3);
        endcase
    endfunction

    task automatic modelReset();
        m_q.delete();
        m_active = 0; m_rem = 0; m_sym = 0; m_mode = 0;
        m_s1 = 0; m_out = 0; m_v1 = 0; m_valid = 0; m_strobe = 0; m_under = 0;
    endtask

    task automatic modelEdge();
        int     lvl;
        int     ticks;
        bit     do_push, load, und;
        longint ai, aq;
        lvl     = m_q.size();
        do_push = sym_if.ipSymbolValid && (lvl < FIFO_DEPTH);
        ai      = m_active ? longint'(ampI(m_sym, m_mode)) : 0;
        aq      = m_active ? longint'(ampQ(m_sym, m_mode)) : 0;
        m_out   = m_s1 >>> SHIFT;
        m_s1    = longint'(ipI) * ai - longint'(ipQ) * aq;
        m_valid = m_v1;
        m_v1    = m_active;
        load = 0; und = 0;
        if (!m_active) begin
            load = ipEnable && lvl > 0;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (ipEnable && lvl > 0) begin
            load = 1;
        end else begin
            m_active = 0;
            und = ipEnable;
        end
        if (load) begin
            ticks    = int'(ipSymbolTicks);
            m_sym    = m_q.pop_front();
            m_mode   = int'(ipMode);
            m_rem    = (ticks == 0) ? 0 : ticks - 1;
            m_active = 1;
        end
        m_strobe = load;
        m_under  = und;
        if (do_push) m_q.push_back(int'(sym_if.ipSymbol));
    endtask

    task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".mod"},    opModulated,          m_out);
        cmp({tag, ".valid"},  opModulatedValid,     m_valid);
        cmp({tag, ".strobe"}, opSymbolStrobe,       m_strobe);
        cmp({tag, ".under"},  opUnderflow,          m_under);
        cmp({tag, ".level"},  opFifoLevel,          m_q.size());
        cmp({tag, ".ready"},  sym_if.opSymbolReady, m_q.size() < FIFO_DEPTH);
    endtask

    task automatic applyStimulus(input string tag);
        @(posedge ipClk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic pushSym(input int s);
        sym_if.ipSymbol      = MAX_BITS'(s);
        sym_if.ipSymbolValid = 1'b1;
        applyStimulus("push");
        sym_if.ipSymbolValid = 1'b0;
    endtask

    task automatic randCarrier();
        ipI = DATA_W'(int'($urandom_range(0, 262143)) - 131072);
        ipQ = DATA_W'(int'($urandom_range(0, 262143)) - 131072);
    endtask

    task automatic midReset();
        #2;
        ipReset = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_async");
        cmp("rst.mod0",   opModulated, 0);
        cmp("rst.ready1", sym_if.opSymbolReady, 1);
        @(negedge ipClk);
        ipReset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int strobes, unders, gap;
        ipReset = 1'b1; ipEnable = 1'b0; ipMode = 2'd0; ipSymbolTicks = '0;
        ipI = '0; ipQ = '0;
        sym_if.ipSymbol = '0; sym_if.ipSymbolValid = 1'b0;
        modelReset();
        #2 ipReset = 1'b0;
        #1;
        checkOutput("por");
        @(negedge ipClk);
        ipReset = 1'b1;
        applyStimulus("idle");

        $display("[TB] QPSK single symbol");
        ipEnable = 1'b1; ipMode = 2'd1; ipSymbolTicks = 16'd4; ipI = 18'sd1000; ipQ = 18'sd500;
        pushSym(2);
        applyStimulus("qpsk");
        cmp("qpsk.strobe", opSymbolStrobe, 1);
        applyStimulus("qpsk");
        applyStimulus("qpsk");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) applyStimulus("qpsk");
            cmp("qpsk.out", opModulated, 187);
            if (i == 2) cmp("qpsk.under", opUnderflow, 1);
        end
        applyStimulus("qpsk");
        cmp("qpsk.drain", opModulated, 0);
        cmp("qpsk.novalid", opModulatedValid, 0);

        $display("[TB] 16-QAM symbol");
        ipMode = 2'd2;
        pushSym(8);
        repeat (3) applyStimulus("q16");
        cmp("q16.out", opModulated, 562);
        repeat (6) applyStimulus("q16");

        $display("[TB] 64-QAM full scale");
        ipMode = 2'd3; ipI = 18'sd131071; ipQ = -18'sd131072;
        pushSym(36);
        repeat (3) applyStimulus("q64");
        cmp("q64.out", opModulated, 229375);
        repeat (6) applyStimulus("q64");

        $display("[TB] fill FIFO then drain back-to-back");
        ipEnable = 1'b0; ipSymbolTicks = '0;
        for (int i = 0; i < 9; i++) begin
            sym_if.ipSymbol = MAX_BITS'($urandom_range(0, 63));
            sym_if.ipSymbolValid = 1'b1;
            randCarrier();
            applyStimulus("fill");
            if (i == 7) begin
                cmp("fill.level8", opFifoLevel, 8);
                cmp("fill.notready", sym_if.opSymbolReady, 0);
            end
        end
        sym_if.ipSymbolValid = 1'b0;
        ipEnable = 1'b1;
        strobes = 0; unders = 0;
        repeat (12) begin
            randCarrier();
            applyStimulus("b2b");
            strobes += int'(opSymbolStrobe);
            unders  += int'(opUnderflow);
        end
        cmp("b2b.strobes", strobes, 8);
        cmp("b2b.unders", unders, 1);

        $display("[TB] mode/ticks change mid-symbol");
        ipMode = 2'd2; ipSymbolTicks = 16'd5;
        pushSym(13);
        pushSym(6);
        cmp("mid.strobe", opSymbolStrobe, 1);
        ipMode = 2'd1; ipSymbolTicks = 16'd2;
        gap = 0;
        for (int i = 0; i < 12; i++) begin
            randCarrier();
            applyStimulus("mid");
            gap++;
            if (opSymbolStrobe) break;
        end
        cmp("mid.gap", gap, 5);
        gap = 0;
        for (int i = 0; i < 12; i++) begin
            randCarrier();
            applyStimulus("mid");
            gap++;
            if (opUnderflow) break;
        end
        cmp("mid.len2", gap, 2);
        repeat (4) applyStimulus("mid");

        $display("[TB] enable dropped mid-symbol");
        ipMode = 2'd2; ipSymbolTicks = 16'd6;
        pushSym(5);
        applyStimulus("drop");
        applyStimulus("drop");
        ipEnable = 1'b0;
        pushSym(9);
        unders = 0;
        repeat (10) begin
            randCarrier();
            applyStimulus("drop");
            unders += int'(opUnderflow);
        end
        cmp("drop.nounder", unders, 0);
        cmp("drop.retained", opFifoLevel, 1);
        cmp("drop.novalid", opModulatedValid, 0);
        ipEnable = 1'b1;
        repeat (10) begin
            randCarrier();
            applyStimulus("resume");
        end

        $display("[TB] asynchronous reset mid-symbol");
        ipMode = 2'd3; ipSymbolTicks = 16'd20;
        pushSym(11); pushSym(22); pushSym(33);
        repeat (4) applyStimulus("prerst");
        midReset();
        repeat (3) applyStimulus("postrst");
        cmp("postrst.level0", opFifoLevel, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            sym_if.ipSymbolValid = ($urandom_range(0, 2) != 0);
            sym_if.ipSymbol      = MAX_BITS'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) ipMode = 2'($urandom_range(0, 3));
            ipSymbolTicks = TICK_W'($urandom_range(0, 3));
            ipEnable      = ($urandom_range(0, 9) != 0);
            randCarrier();
            applyStimulus("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
